inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
Front-end fetch stage directly upstream of the instruction memory. Holds the program counter and drives the word address into the combinational instruction memory. Captures the returned instruction with its PC into an IF/ID output register, using a valid/ready handshake toward decode. Handles redirects (branch/jump), halt, and fetch faults.

Parameters:
ADDR_WIDTH, `MEM_ADDR_WIDTH, instruction memory word-address width
IMEM_DEPTH, `IMEM_DEPTH, number of valid instruction words
XLEN, `WORD_WIDTH, PC and instruction width
RESET_PC, 0, byte address loaded into PC on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  leave IDLE and begin fetching
halt_i  in  1  stop fetching (sticky until reset)
redirect_valid_i  in  1  branch/jump taken this cycle
redirect_pc_i  in  XLEN  byte target of redirect
imem_addr_o  out  ADDR_WIDTH  word address to instruction memory
imem_inst_i  in  XLEN  instruction returned combinationally for imem_addr_o
if_id_valid_o  out  1  output register holds a fetched instruction
if_id_ready_i  in  1  decode accepts the output register this cycle
if_id_inst_o  out  XLEN  fetched instruction
if_id_pc_o  out  XLEN  byte PC of fetched instruction
fault_o  out  1  fetch fault latched
fault_pc_o  out  XLEN  offending PC
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, if_id_valid_o=0, if_id_inst_o=0, if_id_pc_o=0, fault_o=0, fault_pc_o=0.
- imem_addr_o = pc[ADDR_WIDTH+1:2], purely combinational from the PC register. The memory is word-indexed and the PC is a byte address.
- FSM states: IDLE=0, RUN=1, HALTED=2, FAULT=3.
  - IDLE -> RUN on start_i. No fetch occurs in IDLE.
  - RUN -> HALTED on halt_i. halt_i has priority over fetch in the same cycle.
  - RUN -> FAULT on a fault condition.
  - HALTED and FAULT are absorbing until reset.
- can_load = !if_id_valid_o || if_id_ready_i.
- Fetch (RUN, no redirect, no fault, can_load):
  - Next edge: if_id_inst_o<=imem_inst_i, if_id_pc_o<=pc, if_id_valid_o<=1, pc<=pc+4.
  - Single-cycle fetch latency. Back-to-back fetches run at one instruction per cycle while ready is held high.
- Stall (RUN, valid=1, ready=0): pc and the output register hold. The output is stable while valid&&!ready.
- Accept without a new fetch: if_id_valid_o<=0 when ready=1 and no fetch occurs (IDLE/HALTED/FAULT or halt cycle).
- Redirect (RUN, redirect_valid_i=1):
  - Highest priority over fetch and stall.
  - Next edge: pc<=redirect_pc_i, if_id_valid_o<=0 (flush, regardless of ready). The instruction at the current PC is discarded.
  - Ignored in IDLE, HALTED and FAULT.
- Fault conditions, evaluated on the PC about to be fetched in RUN:
  - pc[1:0]!=0 (misaligned, e.g. a bad redirect target).
  - pc[XLEN-1:2] >= IMEM_DEPTH (out of range).
  - On fault: state<=FAULT, fault_o<=1, fault_pc_o<=pc. No instruction is loaded.
  - An already-valid output register still drains normally via ready.
- Simultaneous halt_i and redirect_valid_i: halt wins and the redirect is dropped.
- Wrap-around: pc+4 is modulo 2^XLEN. Exceeding IMEM_DEPTH faults before any wrap is observable.
- Reset mid-operation: everything returns to reset values immediately (async). Fetch resumes only after a new start_i.

Decomposition:
- constants.vh gains: `FETCH_RESET_PC, the state encodings `FS_IDLE/`FS_RUN/`FS_HALTED/`FS_FAULT, and `INST_NOP (32'h00000013) for bench use.
- One natural sub-module: if_id_reg. It is the valid/ready output register with load, hold and flush controls.
- PC/FSM logic stays in inst_fetch_unit.

Test Plan:
- Reset, then start_i pulse, with memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193 and ready=1 -> if_id outputs (pc, inst) are (0,0x13), (4,0x00100093), (8,…), (12,…) on consecutive cycles, with imem_addr_o=0,1,2,3.
- ready=0 for 3 cycles while valid=1 at pc=8 -> if_id_pc_o=8 and inst are held, pc and imem_addr_o hold at 12/3, no skipped instruction after ready returns.
- redirect_valid_i=1 with target 0x20 while ready=0 and valid=1 -> valid=0 next cycle, then next fetch shows if_id_pc_o=0x20 with imem_addr_o=8.
- redirect target 0x22 -> the next cycle shows state_o=FAULT, fault_o=1, fault_pc_o=0x22, and if_id_valid_o stays 0 afterwards.
- Sequential fetch to pc=4*IMEM_DEPTH -> FAULT with fault_pc_o=4*IMEM_DEPTH, and the last valid instruction (pc=4*IMEM_DEPTH-4) is delivered.
- halt_i and redirect_valid_i asserted together in RUN -> state HALTED, pc unchanged, pending output drains when ready=1; rst_n low mid-stream -> all outputs are 0 immediately and state_o=IDLE.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Default widths are sized for a small on-chip instruction memory.
package inst_fetch_unit_pkg;

   localparam int MEM_ADDR_WIDTH = 8;
   localparam int IMEM_DEPTH_DEF = 16;
   localparam int WORD_WIDTH     = 32;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INST_NOP       = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2,
      FS_FAULT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake.
// A flush overrides load, and load overrides the drain caused by ready.
module inst_fetch_unit_if_id_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            flush,
   input  logic            ready,
   input  logic [XLEN-1:0] inst_d,
   input  logic [XLEN-1:0] pc_d,
   output logic            valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc
);

   logic            valid_reg;
   logic [XLEN-1:0] inst_reg;
   logic [XLEN-1:0] pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         inst_reg  <= '0;
         pc_reg    <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
         inst_reg  <= inst_d;
         pc_reg    <= pc_d;
      end else if (ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign inst  = inst_reg;
   assign pc    = pc_reg;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC register and control FSM feeding a combinational instruction
// memory, with the fetched word captured into the IF/ID register.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int              ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int              IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int              XLEN       = WORD_WIDTH,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(FETCH_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  halt_i,
   input  logic                  redirect_valid_i,
   input  logic [XLEN-1:0]       redirect_pc_i,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [XLEN-1:0]       imem_inst_i,
   output logic                  if_id_valid_o,
   input  logic                  if_id_ready_i,
   output logic [XLEN-1:0]       if_id_inst_o,
   output logic [XLEN-1:0]       if_id_pc_o,
   output logic                  fault_o,
   output logic [XLEN-1:0]       fault_pc_o,
   output logic [1:0]            state_o
);

   localparam logic [XLEN-3:0] DEPTH_LIMIT = (XLEN-2)'(IMEM_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);

   fetch_state_t    state_reg;
   logic [XLEN-1:0] pc_reg;
   logic            fault_reg;
   logic [XLEN-1:0] fault_pc_reg;

   logic can_load;
   logic fault_cond;
   logic load;
   logic flush;

   assign can_load   = !if_id_valid_o || if_id_ready_i;
   assign fault_cond = (pc_reg[1:0] != 2'b00) || (pc_reg[XLEN-1:2] >= DEPTH_LIMIT);

   // Halt beats redirect, redirect beats fault, fault beats fetch.
   always_comb begin
      load  = 1'b0;
      flush = 1'b0;
      if (state_reg == FS_RUN && !halt_i) begin
         if (redirect_valid_i)
            flush = 1'b1;
         else if (!fault_cond && can_load)
            load = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= FS_IDLE;
         pc_reg       <= RESET_PC;
         fault_reg    <= 1'b0;
         fault_pc_reg <= '0;
      end else begin
         case (state_reg)
            FS_IDLE: begin
               if (start_i)
                  state_reg <= FS_RUN;
            end
            FS_RUN: begin
               if (halt_i) begin
                  state_reg <= FS_HALTED;
               end else if (redirect_valid_i) begin
                  pc_reg <= redirect_pc_i;
               end else if (fault_cond) begin
                  state_reg    <= FS_FAULT;
                  fault_reg    <= 1'b1;
                  fault_pc_reg <= pc_reg;
               end else if (can_load) begin
                  pc_reg <= pc_reg + PC_STEP;
               end
            end
            default: state_reg <= state_reg;
         endcase
      end
   end

   inst_fetch_unit_if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .flush  (flush),
      .ready  (if_id_ready_i),
      .inst_d (imem_inst_i),
      .pc_d   (pc_reg),
      .valid  (if_id_valid_o),
      .inst   (if_id_inst_o),
      .pc     (if_id_pc_o)
   );

   assign imem_addr_o = pc_reg[ADDR_WIDTH+1:2];
   assign fault_o     = fault_reg;
   assign fault_pc_o  = fault_pc_reg;
   assign state_o     = state_reg;

endmodule
